// File: rtl/nbout_psum_buf.sv
// NBout partial-sum buffer: returns stored partial sums to the lane adders,
// captures the lane results after a fixed pipe latency and drains finished tiles.
module nbout_psum_buf #(
  parameter int N        = 16,
  parameter int Tn       = 16,
  parameter int DEPTH    = 4,
  parameter int PIPE_LAT = 3,
  parameter int EW       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_issue_valid,
  input  logic [EW-1:0]   i_issue_entry,
  input  logic            i_issue_first,
  input  logic            i_issue_last,
  output logic            o_issue_ready,
  output logic [Tn*N-1:0] o_part_sum,
  input  logic [Tn*N-1:0] i_n0,
  output logic            o_out_valid,
  output logic [EW-1:0]   o_out_entry,
  output logic [Tn*N-1:0] o_out_data,
  input  logic            i_out_ready,
  output logic            o_err
);

  localparam int W = Tn * N;

  typedef enum logic [1:0] {EMPTY = 2'd0, ACCUM = 2'd1, DONE = 2'd2} entry_state_t;

  entry_state_t     state_reg [DEPTH];
  logic [DEPTH-1:0] last_pend_reg;
  logic [W-1:0]     mem [DEPTH];
  logic             tag_valid_reg [PIPE_LAT];
  logic [EW-1:0]    tag_entry_reg [PIPE_LAT];
  logic             tag_first_reg [PIPE_LAT];
  logic             tag_last_reg  [PIPE_LAT];
  logic [W-1:0]     part_sum_reg;
  logic [W-1:0]     part_sum_next;
  logic             err_reg;

  logic             accept;
  logic             drain;
  logic             wb_valid;
  logic             wb_last;
  logic [EW-1:0]    wb_entry;
  logic             pre_valid;
  logic             pre_first;
  logic [EW-1:0]    pre_entry;
  entry_state_t     pre_state;
  logic             pre_err;
  logic [DEPTH-1:0] done;
  logic [EW-1:0]    out_entry;

  assign o_issue_ready = !(state_reg[i_issue_entry] == DONE || last_pend_reg[i_issue_entry]);
  assign accept        = i_issue_valid && o_issue_ready;

  assign wb_valid = tag_valid_reg[PIPE_LAT-1];
  assign wb_entry = tag_entry_reg[PIPE_LAT-1];
  assign wb_last  = tag_last_reg[PIPE_LAT-1];

  // The beat that writes back next cycle; its partial sum is fetched now so
  // o_part_sum can come straight from a register.
  generate
    if (PIPE_LAT == 1) begin : g_pre_issue
      assign pre_valid = accept;
      assign pre_entry = i_issue_entry;
      assign pre_first = i_issue_first;
    end else begin : g_pre_tag
      assign pre_valid = tag_valid_reg[PIPE_LAT-2];
      assign pre_entry = tag_entry_reg[PIPE_LAT-2];
      assign pre_first = tag_first_reg[PIPE_LAT-2];
    end
  endgenerate

  // State and data seen at writeback include this cycle's writeback.
  always_comb begin
    pre_state     = state_reg[pre_entry];
    part_sum_next = '0;
    if (wb_valid && wb_entry == pre_entry)
      pre_state = wb_last ? DONE : ACCUM;
    pre_err = pre_valid && ((!pre_first && pre_state == EMPTY) ||
                            (pre_first && pre_state == ACCUM));
    if (pre_valid && !pre_first && pre_state != EMPTY)
      part_sum_next = (wb_valid && wb_entry == pre_entry) ? i_n0 : mem[pre_entry];
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_done
      assign done[gi] = (state_reg[gi] == DONE);
    end
  endgenerate

  always_comb begin
    out_entry = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (done[i]) out_entry = EW'(i);
  end

  assign o_out_valid = |done;
  assign o_out_entry = out_entry;
  assign o_out_data  = mem[out_entry];
  assign drain       = o_out_valid && i_out_ready;
  assign o_part_sum  = part_sum_reg;
  assign o_err       = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_reg[i] <= EMPTY;
        mem[i]       <= '0;
      end
      for (int s = 0; s < PIPE_LAT; s++) begin
        tag_valid_reg[s] <= 1'b0;
        tag_entry_reg[s] <= '0;
        tag_first_reg[s] <= 1'b0;
        tag_last_reg[s]  <= 1'b0;
      end
      last_pend_reg <= '0;
      part_sum_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      tag_valid_reg[0] <= accept;
      tag_entry_reg[0] <= i_issue_entry;
      tag_first_reg[0] <= i_issue_first;
      tag_last_reg[0]  <= i_issue_last;
      for (int s = 1; s < PIPE_LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_entry_reg[s] <= tag_entry_reg[s-1];
        tag_first_reg[s] <= tag_first_reg[s-1];
        tag_last_reg[s]  <= tag_last_reg[s-1];
      end
      part_sum_reg <= part_sum_next;
      if (pre_err) err_reg <= 1'b1;
      if (wb_valid) begin
        mem[wb_entry]       <= i_n0;
        state_reg[wb_entry] <= wb_last ? DONE : ACCUM;
        if (wb_last) last_pend_reg[wb_entry] <= 1'b0;
      end
      // DONE entries accept no beats, so drain never collides with writeback.
      if (drain) state_reg[out_entry] <= EMPTY;
      if (accept && i_issue_last) last_pend_reg[i_issue_entry] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nbout_psum_buf.sv
// Bench for nbout_psum_buf: partial sums and drained tiles are predicted as
// beats are issued and checked when the DUT writes back or drains.
module tb_nbout_psum_buf;

  localparam int N = 16, TN = 16, DEPTH = 4, PL = 3, EW = 2, W = TN * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid, issue_first, issue_last, issue_ready;
  logic [EW-1:0] issue_entry;
  logic [W-1:0]  part_sum, n0, out_data;
  logic          out_valid, out_ready, err;
  logic [EW-1:0] out_entry;

  nbout_psum_buf #(.N(N), .Tn(TN), .DEPTH(DEPTH), .PIPE_LAT(PL), .EW(EW)) dut (
    .clk(clk), .rst(rst),
    .i_issue_valid(issue_valid), .i_issue_entry(issue_entry),
    .i_issue_first(issue_first), .i_issue_last(issue_last),
    .o_issue_ready(issue_ready), .o_part_sum(part_sum), .i_n0(n0),
    .o_out_valid(out_valid), .o_out_entry(out_entry), .o_out_data(out_data),
    .i_out_ready(out_ready), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [EW-1:0] e;
    logic [W-1:0]  d;
  } drain_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic         fl_valid [PL];
  logic [W-1:0] fl_val   [PL];
  logic [W-1:0] psum_q [$];
  drain_t       drain_q [$];
  logic [W-1:0] mval  [DEPTH];
  bit           mopen [DEPTH];
  bit           acc_pending;
  logic [W-1:0] acc_val;
  logic [W-1:0] junk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] vec(input logic [N-1:0] base, input logic [N-1:0] inc);
    logic [W-1:0] v;
    for (int i = 0; i < TN; i++) v[i*N +: N] = base + N'(i) * inc;
    return v;
  endfunction

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic tick();
    drain_t       d;
    logic [W-1:0] exp;
    n0 = fl_valid[PL-1] ? fl_val[PL-1] : junk;
    @(negedge clk);
    if (fl_valid[PL-1]) begin
      exp = (psum_q.size() > 0) ? psum_q.pop_front() : {W{1'bx}};
      check("part_sum", part_sum, exp);
    end else begin
      check("part_sum_idle", part_sum, '0);
    end
    if (out_ready) begin
      if (drain_q.size() > 0) begin
        d = drain_q.pop_front();
        check("drain_valid", out_valid, 1'b1);
        check("drain_entry", out_entry, d.e);
        check("drain_data", out_data, d.d);
      end else begin
        check("drain_idle", out_valid, 1'b0);
      end
    end
    @(posedge clk);
    #1;
    for (int s = PL - 1; s > 0; s--) begin
      fl_valid[s] = fl_valid[s-1];
      fl_val[s]   = fl_val[s-1];
    end
    fl_valid[0] = acc_pending;
    fl_val[0]   = acc_val;
    acc_pending = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic issue(input logic [EW-1:0] e, input bit first, input bit last,
                       input logic [W-1:0] val);
    issue_valid = 1'b1;
    issue_entry = e;
    issue_first = first;
    issue_last  = last;
    #1;
    check("issue_ready", issue_ready, 1'b1);
    psum_q.push_back((!first && mopen[e]) ? mval[e] : '0);
    mopen[e]    = !last;
    mval[e]     = val;
    acc_pending = 1'b1;
    acc_val     = val;
    tick();
  endtask

  task automatic pulse_ready(input logic [EW-1:0] e, input logic [W-1:0] d);
    drain_q.push_back('{e: e, d: d});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_part_sum", part_sum, '0);
    check("rst_err", err, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_entry", out_entry, '0);
    for (int s = 0; s < PL; s++) fl_valid[s] = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      mopen[e] = 1'b0;
      mval[e]  = '0;
    end
    psum_q.delete();
    drain_q.delete();
    acc_pending = 1'b0;
    issue_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      issue_entry = EW'(e);
      #1;
      check("rst_issue_ready", issue_ready, 1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_entry = '0; issue_first = 1'b0;
    issue_last = 1'b0; out_ready = 1'b0; acc_val = '0;
    junk = vec(16'hBEEF, 16'h0101);
    n0 = junk;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();

    // Two-beat tile on e0 with back-to-back beats
    issue(2'd0, 1'b1, 1'b0, vec(16'h0005, 16'h0000));
    issue(2'd0, 1'b0, 1'b1, vec(16'h000C, 16'h0000));
    repeat (3) tick();
    check("t2_valid", out_valid, 1'b1);
    check("t2_entry", out_entry, 2'd0);
    check("t2_data", out_data, vec(16'h000C, 16'h0000));
    pulse_ready(2'd0, vec(16'h000C, 16'h0000));
    check("t2_empty", out_valid, 1'b0);

    // Lowest-index drain priority and hold while not ready
    issue(2'd2, 1'b1, 1'b1, vec(16'h0A10, 16'h0001));
    issue(2'd0, 1'b1, 1'b1, vec(16'h0B20, 16'h0003));
    repeat (3) tick();
    for (int c = 0; c < 10; c++) begin
      check("t3_hold_valid", out_valid, 1'b1);
      check("t3_hold_entry", out_entry, 2'd0);
      check("t3_hold_data", out_data, vec(16'h0B20, 16'h0003));
      tick();
    end
    pulse_ready(2'd0, vec(16'h0B20, 16'h0003));
    check("t3_next_entry", out_entry, 2'd2);
    check("t3_next_data", out_data, vec(16'h0A10, 16'h0001));
    pulse_ready(2'd2, vec(16'h0A10, 16'h0001));
    check("t3_empty", out_valid, 1'b0);

    // Last beat pending and DONE both block further beats
    issue(2'd1, 1'b1, 1'b1, vec(16'h1100, 16'h0002));
    for (int c = 0; c < 5; c++) begin
      issue_valid = 1'b1;
      issue_entry = 2'd1;
      issue_first = 1'b0;
      issue_last  = 1'b0;
      #1;
      check("t4_blocked", issue_ready, 1'b0);
      tick();
    end
    pulse_ready(2'd1, vec(16'h1100, 16'h0002));
    issue_entry = 2'd1;
    #1;
    check("t4_reopened", issue_ready, 1'b1);
    @(posedge clk);
    #1;

    // Non-first beat to an EMPTY entry flags an error and starts from zero
    check("t5_err_before", err, 1'b0);
    issue(2'd3, 1'b0, 1'b1, vec(16'h3300, 16'h0005));
    repeat (3) tick();
    check("t5_err_set", err, 1'b1);
    pulse_ready(2'd3, vec(16'h3300, 16'h0005));
    issue(2'd1, 1'b1, 1'b0, vec(16'h0040, 16'h0007));
    issue(2'd1, 1'b0, 1'b0, vec(16'h0050, 16'h0011));
    issue(2'd1, 1'b0, 1'b1, vec(16'h0060, 16'h0013));
    repeat (3) tick();
    pulse_ready(2'd1, vec(16'h0060, 16'h0013));
    check("t5_err_sticky", err, 1'b1);

    // Reset with beats in flight and a DONE entry
    issue(2'd0, 1'b1, 1'b1, vec(16'h0007, 16'h0001));
    repeat (3) tick();
    check("t6_done_before", out_valid, 1'b1);
    issue(2'd1, 1'b1, 1'b0, vec(16'h0100, 16'h0001));
    issue(2'd1, 1'b0, 1'b0, vec(16'h0200, 16'h0001));
    issue(2'd1, 1'b0, 1'b0, vec(16'h0300, 16'h0001));
    do_reset();
    repeat (5) tick();
    check("t6_no_done", out_valid, 1'b0);
    check("t6_mem_cleared", out_data, '0);
    check("t6_err_cleared", err, 1'b0);
    issue(2'd2, 1'b1, 1'b1, vec(16'h0777, 16'h0009));
    repeat (3) tick();
    pulse_ready(2'd2, vec(16'h0777, 16'h0009));
    check("t6_final_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
